// File: rtl/vt52_pkg.sv
// Shared timing constants for the VT52-style text display: sync timing,
// character cell geometry, buffer size and the arbiter state encoding.
package vt52_pkg;

  localparam int CNT_W    = 11;
  localparam int ADDR_W   = 11;

  localparam int HBP      = 248;
  localparam int VBP      = 150;
  localparam int COLS     = 80;
  localparam int ROWS     = 25;
  localparam int CHAR_W   = 16;
  localparam int CHAR_H   = 32;
  localparam int BUF_SIZE = COLS * ROWS;

  localparam int CW_BITS  = $clog2(CHAR_W);
  localparam int CH_BITS  = $clog2(CHAR_H);

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Sized forms of the constants used in compares and adds.
  localparam cnt_t  VBP_C      = cnt_t'(VBP);
  localparam cnt_t  VIS_END_C  = cnt_t'(VBP + ROWS * CHAR_H);
  localparam cnt_t  SLOT0_C    = cnt_t'(HBP - 2);
  localparam cnt_t  ROWUPD_C   = cnt_t'(HBP - 3);
  localparam cnt_t  COLS_CNT_C = cnt_t'(COLS);
  localparam addr_t COLS_C     = addr_t'(COLS);
  localparam addr_t BUF_C      = addr_t'(BUF_SIZE);
  localparam logic [4:0] ROWS_C = 5'(ROWS);

  // Writer FSM encoding.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  // Add two in-buffer offsets and fold the result back into the buffer.
  // Both operands are below BUF_SIZE, so one subtraction is enough.
  function automatic addr_t wrap_add(input addr_t a, input addr_t b);
    logic [ADDR_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, BUF_C}) begin
      sum = sum - {1'b0, BUF_C};
    end else begin
      sum = sum;
    end
    return sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/vram_addr_gen.sv
// Display-side address generation: scroll latch, incremental row base with
// wrap, fetch slot decode with column index, and glyph line register.
module vram_addr_gen
  import vt52_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CNT_W-1:0]   hc,
  input  logic [CNT_W-1:0]   vc,
  input  logic [4:0]         first_row,
  output logic               slot,
  output logic [ADDR_W-1:0]  slot_addr,
  output logic [CH_BITS-1:0] char_row
);

  logic [ADDR_W-1:0]  base_q, base_d;
  logic [4:0]         fr_cnt_q, fr_cnt_d;
  logic [CH_BITS-1:0] char_row_q, char_row_d;

  cnt_t hc_off_s;
  cnt_t vc_off_s;
  cnt_t col_s;
  logic visible_s;
  logic frame_start_s;
  logic row_step_s;
  logic scroll_step_s;

  // Decode the beam position into slot, column and row-advance events.
  always_comb begin
    hc_off_s      = hc - SLOT0_C;
    vc_off_s      = vc - VBP_C;
    col_s         = hc_off_s >> CW_BITS;
    visible_s     = (vc >= VBP_C) && (vc < VIS_END_C);
    frame_start_s = (hc == 11'd0) && (vc == 11'd0);
    // Pre-roll the base by one row per back-porch line until the scroll
    // offset is consumed; ROWS is far below VBP so this always finishes.
    scroll_step_s = (hc == 11'd0) && (vc != 11'd0) && (vc < VBP_C) && (fr_cnt_q != 5'd0);
    // A new character row starts every CHAR_H visible lines (row 0 excluded).
    row_step_s    = visible_s && (hc == 11'd0) && (vc != VBP_C)
                    && (vc_off_s[CH_BITS-1:0] == {CH_BITS{1'b0}});
    slot          = visible_s && (hc >= SLOT0_C)
                    && (hc_off_s[CW_BITS-1:0] == {CW_BITS{1'b0}})
                    && (col_s < COLS_CNT_C);
    slot_addr     = wrap_add(base_q, col_s[ADDR_W-1:0]);
  end

  // Scroll latch at frame start and incremental row base with wrap.
  always_comb begin
    fr_cnt_d = fr_cnt_q;
    base_d   = base_q;
    if (frame_start_s) begin
      fr_cnt_d = (first_row < ROWS_C) ? first_row : 5'd0;
      base_d   = {ADDR_W{1'b0}};
    end else if (scroll_step_s) begin
      fr_cnt_d = fr_cnt_q - 5'd1;
      base_d   = wrap_add(base_q, COLS_C);
    end else if (row_step_s) begin
      fr_cnt_d = fr_cnt_q;
      base_d   = wrap_add(base_q, COLS_C);
    end else begin
      fr_cnt_d = fr_cnt_q;
      base_d   = base_q;
    end
  end

  // Capture the glyph line just before the first fetch slot of the line.
  always_comb begin
    if (visible_s && (hc == ROWUPD_C)) begin
      char_row_d = vc_off_s[CH_BITS-1:0];
    end else begin
      char_row_d = char_row_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= {ADDR_W{1'b0}};
      fr_cnt_q   <= 5'd0;
      char_row_q <= {CH_BITS{1'b0}};
    end else begin
      base_q     <= base_d;
      fr_cnt_q   <= fr_cnt_d;
      char_row_q <= char_row_d;
    end
  end

  assign char_row = char_row_q;

endmodule

// File: rtl/vram_arbiter.sv
// Character RAM arbiter: display fetch has absolute priority on the RAM
// port; the terminal writer is granted any other cycle via req/ack.
module vram_arbiter
  import vt52_pkg::*;
(
  input  logic              px_clk,
  input  logic              clr_n,
  input  logic [10:0]       hc,
  input  logic [10:0]       vc,
  input  logic [4:0]        first_row,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              ack,
  output logic [7:0]        ack_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        char_code,
  output logic [4:0]        char_row
);

  logic [0:0]        state_q, state_d;
  logic              rd_ok_q, rd_ok_d;
  logic              fetch_q, fetch_d;
  logic [7:0]        char_code_q, char_code_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;

  logic              slot_s;
  logic [ADDR_W-1:0] slot_addr_s;
  logic              grant_s;
  logic              in_range_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic              ram_we_s;

  vram_addr_gen u_addr_gen (
    .clk       (px_clk),
    .rst_n     (clr_n),
    .hc        (hc),
    .vc        (vc),
    .first_row (first_row),
    .slot      (slot_s),
    .slot_addr (slot_addr_s),
    .char_row  (char_row)
  );

  // RAM port mux: fetch slot first, then a writer grant, else hold address.
  always_comb begin
    in_range_s = (req_addr < BUF_C);
    grant_s    = (state_q == ST_IDLE) && req && !slot_s;
    if (slot_s) begin
      ram_addr_s = slot_addr_s;
    end else if (grant_s) begin
      ram_addr_s = req_addr;
    end else begin
      ram_addr_s = ram_addr_q;
    end
    // Writes outside the buffer are dropped; nothing writes while in reset.
    ram_we_s = grant_s && req_we && in_range_s && clr_n;
  end

  // Writer FSM: a grant is always followed by exactly one ACK cycle.
  always_comb begin
    state_d = ST_IDLE;
    rd_ok_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          state_d = ST_ACK;
          rd_ok_d = !req_we && in_range_s;
        end else begin
          state_d = ST_IDLE;
          rd_ok_d = 1'b0;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        rd_ok_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        rd_ok_d = 1'b0;
      end
    endcase
  end

  // Fetch return path: RAM data for a slot arrives one cycle later.
  always_comb begin
    fetch_d    = slot_s;
    ram_addr_d = ram_addr_s;
    if (fetch_q) begin
      char_code_d = ram_rdata;
    end else begin
      char_code_d = char_code_q;
    end
  end

  // State registers.
  always_ff @(posedge px_clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_IDLE;
      rd_ok_q     <= 1'b0;
      fetch_q     <= 1'b0;
      char_code_q <= 8'h00;
      ram_addr_q  <= {ADDR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      rd_ok_q     <= rd_ok_d;
      fetch_q     <= fetch_d;
      char_code_q <= char_code_d;
      ram_addr_q  <= ram_addr_d;
    end
  end

  assign ack       = (state_q == ST_ACK);
  assign ack_rdata = rd_ok_q ? ram_rdata : 8'h00;
  assign ram_addr  = ram_addr_s;
  assign ram_we    = ram_we_s;
  assign ram_wdata = req_wdata;
  assign char_code = char_code_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency RAM
// preloaded with addr[7:0], and queues of expected ack/char codes.
module tb_vram_arbiter;

  logic        px_clk = 1'b0;
  logic        clr_n;
  logic [10:0] hc, vc;
  logic [4:0]  first_row;
  logic        req, req_we;
  logic [10:0] req_addr;
  logic [7:0]  req_wdata;
  logic        ack;
  logic [7:0]  ack_rdata;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  char_code;
  logic [4:0]  char_row;

  int total = 0;
  int bad   = 0;

  logic [7:0] ack_exp_q [$];
  logic [7:0] code_q [$];

  logic [7:0] mem [0:2047];
  logic       init_done = 1'b0;

  vram_arbiter dut (
    .px_clk    (px_clk),
    .clr_n     (clr_n),
    .hc        (hc),
    .vc        (vc),
    .first_row (first_row),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .ack_rdata (ack_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .char_code (char_code),
    .char_row  (char_row)
  );

  always #5 px_clk = ~px_clk;

  // Synchronous RAM: registered address, read-before-write, preload addr[7:0].
  always @(posedge px_clk) begin
    if (!init_done) begin
      for (int i = 0; i < 2048; i++) mem[i] <= i[7:0];
      init_done <= 1'b1;
      ram_rdata <= ram_addr[7:0];
    end else begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [10:0] h, input logic [10:0] v);
    @(negedge px_clk);
    hc = h;
    vc = v;
    #1;
  endtask

  task automatic frame_start(input logic [4:0] fr);
    first_row = fr;
    cyc(11'd0, 11'd0);
    for (int v = 1; v < 150; v++) cyc(11'd0, 11'(v));
  endtask

  task automatic skip_lines(input int v0, input int v1);
    for (int v = v0; v <= v1; v++) cyc(11'd0, 11'(v));
  endtask

  // Sweep one line from hc=0, checking fetch addresses and char_code timing.
  task automatic sweep(input int v, input int hlast, input int exp_base);
    logic [7:0] last_code;
    last_code = 8'h00;
    code_q.delete();
    for (int h = 0; h <= hlast; h++) begin
      cyc(11'(h), 11'(v));
      if (h >= 246 && ((h - 246) % 16 == 0) && ((h - 246) / 16 < 80)) begin
        int a;
        a = (exp_base + (h - 246) / 16) % 2000;
        chk($sformatf("slot_addr v%0d h%0d", v, h), 32'(ram_addr), 32'(a));
        chk($sformatf("slot_we v%0d h%0d", v, h), 32'(ram_we), 32'd0);
        code_q.push_back(a[7:0]);
      end
      if (h >= 248 && ((h - 248) % 16 == 0) && code_q.size() > 0) begin
        last_code = code_q.pop_front();
        chk($sformatf("code_first v%0d h%0d", v, h), 32'(char_code), 32'(last_code));
      end
      if (h >= 263 && ((h - 248) % 16 == 15)) begin
        chk($sformatf("code_hold v%0d h%0d", v, h), 32'(char_code), 32'(last_code));
      end
    end
  endtask

  // Off-screen writer access with bounded wait for ack.
  task automatic access(input logic we, input logic [10:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input logic exp_we, input string tag);
    logic       got;
    int         lat;
    logic [7:0] e;
    ack_exp_q.push_back(exp_rd);
    @(negedge px_clk);
    hc = 11'd5; vc = 11'd0;
    req = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    #1;
    chk({tag, "_grant_addr"}, 32'(ram_addr), 32'(a));
    chk({tag, "_grant_we"}, 32'(ram_we), 32'(exp_we));
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 4 && !got; i++) begin
      @(negedge px_clk);
      #1;
      if (ack) begin
        got = 1'b1;
        lat = i;
      end
    end
    e = ack_exp_q.pop_front();
    chk({tag, "_latency"}, 32'(lat), 32'd1);
    if (got) chk({tag, "_rdata"}, 32'(ack_rdata), 32'(e));
    else     chk({tag, "_ack_seen"}, 32'(got), 32'd1);
    req = 1'b0;
  endtask

  initial begin
    clr_n = 1'b0; req = 1'b1; req_we = 1'b1; req_addr = 11'd7; req_wdata = 8'h5A;
    hc = 11'd0; vc = 11'd0; first_row = 5'd0;

    // Reset held with a pending write request.
    for (int i = 0; i < 3; i++) begin
      cyc(11'd0, 11'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_code", 32'(char_code), 32'd0);
      chk("rst_row", 32'(char_row), 32'd0);
    end
    ack_exp_q.push_back(8'h00);
    @(negedge px_clk);
    clr_n = 1'b1;
    #1;
    chk("rel_grant_ack", 32'(ack), 32'd0);
    chk("rel_grant_we", 32'(ram_we), 32'd1);
    cyc(11'd0, 11'd0);
    chk("rel_ack", 32'(ack), 32'd1);
    chk("rel_rdata", 32'(ack_rdata), 32'(ack_exp_q.pop_front()));
    req = 1'b0;

    // Plain accesses and buffer-end boundaries.
    access(1'b0, 11'd7,    8'h00, 8'h5A, 1'b0, "rd7");
    access(1'b1, 11'd100,  8'h33, 8'h00, 1'b1, "wr100");
    access(1'b0, 11'd100,  8'h00, 8'h33, 1'b0, "rd100");
    access(1'b1, 11'd1999, 8'h77, 8'h00, 1'b1, "wr1999");
    access(1'b0, 11'd1999, 8'h00, 8'h77, 1'b0, "rd1999");
    access(1'b1, 11'd2000, 8'h55, 8'h00, 1'b0, "wr2000");
    access(1'b0, 11'd2000, 8'h00, 8'h00, 1'b0, "rd2000");

    // Fetch timing and row advance, no scroll.
    frame_start(5'd0);
    sweep(150, 270, 0);
    skip_lines(151, 159);
    sweep(160, 250, 0);
    chk("row_v160", 32'(char_row), 32'd10);
    skip_lines(161, 181);
    sweep(182, 250, 80);
    chk("row_v182", 32'(char_row), 32'd0);

    // Writer collides with the first fetch slot.
    frame_start(5'd0);
    sweep(150, 245, 0);
    cyc(11'd246, 11'd150);
    req = 1'b1; req_we = 1'b1; req_addr = 11'd5; req_wdata = 8'h41;
    #1;
    chk("col_slot_addr", 32'(ram_addr), 32'd0);
    chk("col_slot_we", 32'(ram_we), 32'd0);
    ack_exp_q.push_back(8'h00);
    cyc(11'd247, 11'd150);
    chk("col_grant_we", 32'(ram_we), 32'd1);
    chk("col_grant_addr", 32'(ram_addr), 32'd5);
    chk("col_grant_ack", 32'(ack), 32'd0);
    cyc(11'd248, 11'd150);
    chk("col_ack", 32'(ack), 32'd1);
    chk("col_ack_rdata", 32'(ack_rdata), 32'(ack_exp_q.pop_front()));
    chk("col_code", 32'(char_code), 32'd0);
    req = 1'b0;
    cyc(11'd249, 11'd150);
    chk("col_ack_pulse", 32'(ack), 32'd0);
    cyc(11'd250, 11'd150);
    req = 1'b1; req_we = 1'b0; req_addr = 11'd5;
    ack_exp_q.push_back(8'h41);
    #1;
    chk("col_rd_addr", 32'(ram_addr), 32'd5);
    cyc(11'd251, 11'd150);
    chk("col_rd_ack", 32'(ack), 32'd1);
    chk("col_rd_rdata", 32'(ack_rdata), 32'(ack_exp_q.pop_front()));
    req = 1'b0;

    // Scroll wrap and out-of-range first_row.
    frame_start(5'd24);
    sweep(150, 250, 1920);
    skip_lines(151, 181);
    sweep(182, 250, 0);
    frame_start(5'd30);
    sweep(150, 250, 0);

    // Reset asserted during the grant cycle: that ack must never appear.
    @(negedge px_clk);
    hc = 11'd5; vc = 11'd0;
    req = 1'b1; req_we = 1'b0; req_addr = 11'd9;
    #1;
    chk("mid_grant_addr", 32'(ram_addr), 32'd9);
    clr_n = 1'b0;
    #1;
    chk("mid_we", 32'(ram_we), 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc(11'd5, 11'd0);
      chk("mid_rst_ack", 32'(ack), 32'd0);
    end
    @(negedge px_clk);
    clr_n = 1'b1;
    req = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      cyc(11'd5, 11'd0);
      chk("mid_lost_ack", 32'(ack), 32'd0);
    end
    access(1'b0, 11'd9, 8'h00, 8'h09, 1'b0, "reissue");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
